// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer around the byte-wide reflected CRC-32 update.
// Accepts a valid/ready byte stream and emits CRC, length and FCS check.
module crc32_frame_ctrl #(
    parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
    parameter logic [31:0] XOR_OUT = 32'hFFFF_FFFF,
    parameter logic [31:0] RESIDUE = 32'hDEBB_20E3,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             abort_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [7:0]       s_data_i,
    input  logic             s_last_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [31:0]      m_crc_o,
    output logic             m_ok_o,
    output logic [LEN_W-1:0] m_len_o,
    output logic             m_len_ovf_o
);

    localparam logic [31:0] POLY = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t state_q, state_d;

    logic [31:0]      crc_q;
    logic [LEN_W-1:0] len_q;
    logic             ovf_q;

    logic [31:0]      res_crc_q;
    logic             res_ok_q;
    logic [LEN_W-1:0] res_len_q;
    logic             res_ovf_q;

    logic             accept;
    logic             first;
    logic             clr;
    logic             upd;
    logic             load;

    logic [31:0]      crc_base;
    logic [31:0]      crc_nxt;
    logic [LEN_W-1:0] len_base;
    logic [LEN_W-1:0] len_nxt;
    logic             ovf_base;
    logic             ovf_nxt;
    logic             len_max;

    assign s_ready_o   = (state_q != DONE);
    assign m_valid_o   = (state_q == DONE);
    assign m_crc_o     = res_crc_q;
    assign m_ok_o      = res_ok_q;
    assign m_len_o     = res_len_q;
    assign m_len_ovf_o = res_ovf_q;

    assign accept = s_valid_i && s_ready_o;
    assign first  = (state_q == IDLE);

    // The first byte of a frame always starts from a fresh INIT/zero base.
    assign crc_base = first ? INIT : crc_q;
    assign crc_nxt  = crc32_byte(crc_base, s_data_i);
    assign len_base = first ? '0 : len_q;
    assign ovf_base = first ? 1'b0 : ovf_q;
    assign len_max  = &len_base;
    assign len_nxt  = len_max ? len_base : len_base + LEN_W'(1);
    assign ovf_nxt  = ovf_base | len_max;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        upd     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE, BUSY: begin
                // Abort wins over a coincident byte, which is dropped.
                if (abort_i) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    upd = 1'b1;
                    if (s_last_i) begin
                        load    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            DONE: begin
                if (m_ready_i) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                clr     = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q     <= INIT;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            res_crc_q <= '0;
            res_ok_q  <= 1'b0;
            res_len_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            if (clr) begin
                crc_q <= INIT;
                len_q <= '0;
                ovf_q <= 1'b0;
            end else if (upd) begin
                crc_q <= crc_nxt;
                len_q <= len_nxt;
                ovf_q <= ovf_nxt;
            end
            if (load) begin
                res_crc_q <= crc_nxt ^ XOR_OUT;
                res_ok_q  <= (crc_nxt == RESIDUE);
                res_len_q <= len_nxt;
                res_ovf_q <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Scoreboard bench for crc32_frame_ctrl (LEN_W=16 and LEN_W=4 in lockstep).
// Directed frames; a negedge monitor checks every presented result.
module tb_crc32_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        abort;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_ready;

    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_crc;
    logic        m_ok;
    logic [15:0] m_len;
    logic        m_ovf;

    logic        s_ready4;
    logic        m_valid4;
    logic [31:0] m_crc4;
    logic        m_ok4;
    logic [3:0]  m_len4;
    logic        m_ovf4;

    crc32_frame_ctrl #(.LEN_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .abort_i(abort),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_data_i(s_data), .s_last_i(s_last),
        .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_crc_o(m_crc), .m_ok_o(m_ok),
        .m_len_o(m_len), .m_len_ovf_o(m_ovf)
    );

    crc32_frame_ctrl #(.LEN_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .abort_i(abort),
        .s_valid_i(s_valid), .s_ready_o(s_ready4),
        .s_data_i(s_data), .s_last_i(s_last),
        .m_valid_o(m_valid4), .m_ready_i(m_ready),
        .m_crc_o(m_crc4), .m_ok_o(m_ok4),
        .m_len_o(m_len4), .m_len_ovf_o(m_ovf4)
    );

    typedef struct packed {
        logic [31:0] crc;
        logic        ok;
        logic [15:0] len;
        logic        ovf;
        logic [3:0]  len4;
        logic        ovf4;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-serial reference: register value before the output XOR.
    function automatic logic [31:0] crc_ref(input logic [7:0] d[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (d[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (rst_ni && m_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got crc %h expected none",
                         m_crc);
            end else begin
                mon_e = sb[0];
                chk("crc", m_crc, mon_e.crc);
                chk("ok", {31'h0, m_ok}, {31'h0, mon_e.ok});
                chk("len", {16'h0, m_len}, {16'h0, mon_e.len});
                chk("len_ovf", {31'h0, m_ovf}, {31'h0, mon_e.ovf});
                chk("s_ready_done", {31'h0, s_ready}, 32'h0);
                chk("valid4", {31'h0, m_valid4}, 32'h1);
                chk("crc4", m_crc4, mon_e.crc);
                chk("len4", {28'h0, m_len4}, {28'h0, mon_e.len4});
                chk("ovf4", {31'h0, m_ovf4}, {31'h0, mon_e.ovf4});
                if (m_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last,
                             input logic ab);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        abort   = ab;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d[$],
                              input logic [31:0] crc, input logic ok);
        exp_t e;
        int   n;
        n      = d.size();
        e.crc  = crc;
        e.ok   = ok;
        e.len  = 16'(n);
        e.ovf  = 1'b0;
        e.len4 = (n > 15) ? 4'hF : 4'(n);
        e.ovf4 = (n > 15);
        for (int i = 0; i < n - 1; i++) send_byte(d[i], 1'b0, 1'b0);
        sb.push_back(e);
        send_byte(d[n-1], 1'b1, 1'b0);
        #3;
        chk("latency", {31'h0, m_valid}, 32'h1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, {31'h0, s_ready}, 32'h1);
        chk({tag, "_m_valid"}, {31'h0, m_valid}, 32'h0);
        chk({tag, "_m_crc"}, m_crc, 32'h0);
        chk({tag, "_m_ok"}, {31'h0, m_ok}, 32'h0);
        chk({tag, "_m_len"}, {16'h0, m_len}, 32'h0);
        chk({tag, "_m_ovf"}, {31'h0, m_ovf}, 32'h0);
        chk({tag, "_m_valid4"}, {31'h0, m_valid4}, 32'h0);
    endtask

    logic [7:0] f9[$];
    logic [7:0] f0[$];
    logic [7:0] ffcs[$];
    logic [7:0] fbad[$];
    logic [7:0] f20[$];
    logic [31:0] r;

    initial begin
        f9   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f0   = '{8'h00};
        ffcs = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        fbad = '{8'h30, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 20; i++) f20.push_back(8'(i * 7 + 3));

        rst_ni  = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b1;
        #3;
        chk_reset("por");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        send_frame(f9, 32'hCBF4_3926, 1'b0);
        @(posedge clk);
        #3;
        chk("back_idle_ready", {31'h0, s_ready}, 32'h1);
        chk("back_idle_valid", {31'h0, m_valid}, 32'h0);

        send_frame(f0, 32'hD202_EF8D, 1'b0);
        @(posedge clk);
        #1;
        send_frame(ffcs, 32'h2144_DF1C, 1'b1);
        @(posedge clk);
        #1;
        r = crc_ref(fbad);
        send_frame(fbad, r ^ 32'hFFFF_FFFF, r == 32'hDEBB_20E3);
        @(posedge clk);
        #1;

        m_ready = 1'b0;
        send_frame(f9, 32'hCBF4_3926, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
        send_frame(f9, 32'hCBF4_3926, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) send_byte(f9[i], 1'b0, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        send_frame(f9, 32'hCBF4_3926, 1'b0);
        @(posedge clk);
        #1;
        send_byte(8'h31, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        chk("abort_last_valid", {31'h0, m_valid}, 32'h0);
        chk("abort_last_ready", {31'h0, s_ready}, 32'h1);
        send_frame(f9, 32'hCBF4_3926, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) send_byte(f9[i], 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset("rst_frame");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        send_frame(f9, 32'hCBF4_3926, 1'b0);
        @(posedge clk);
        #1;

        m_ready = 1'b0;
        send_frame(ffcs, 32'h2144_DF1C, 1'b1);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        chk_reset("rst_done");
        @(posedge clk);
        #1;
        rst_ni  = 1'b1;
        m_ready = 1'b1;
        send_frame(f0, 32'hD202_EF8D, 1'b0);
        @(posedge clk);
        #1;

        r = crc_ref(f20);
        send_frame(f20, r ^ 32'hFFFF_FFFF, r == 32'hDEBB_20E3);

        begin
            int n;
            n = 0;
            while (sb.size() > 0 && n < 100) begin
                @(posedge clk);
                n++;
            end
            if (sb.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d pending expected 0",
                         sb.size());
            end
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/crc32_frame_ctrl.md
Name: crc32_frame_ctrl

Overview:
Frame-level sequencer for the byte-wide reflected CRC-32 next-state function (poly 0xEDB88320, right shift, 8-bit input word). It instantiates that combinational function, owns the 32-bit CRC state register, and accepts a valid/ready byte stream with an end-of-frame marker. Per frame it delivers the final CRC, the byte count and an FCS residue-check flag over a valid/ready result port. It sits between the MAC receive/transmit byte path and the framing logic.

Parameters:
INIT, 32'hFFFF_FFFF, CRC register value loaded at frame start
XOR_OUT, 32'hFFFF_FFFF, value XORed onto the register to form m_crc_o
RESIDUE, 32'hDEBB_20E3, register value (before XOR_OUT) that marks a good frame with its FCS appended
LEN_W, 16, byte-counter width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
abort_i  in  1  synchronous abort; drops the current frame
s_valid_i  in  1  input byte valid
s_ready_o  out  1  input byte accepted when s_valid_i && s_ready_o
s_data_i  in  8  input byte, bit 0 first on the wire
s_last_i  in  1  qualifies the final byte of the frame
m_valid_o  out  1  result valid
m_ready_i  in  1  result consumed when m_valid_o && m_ready_i
m_crc_o  out  32  final CRC = state ^ XOR_OUT
m_ok_o  out  1  state == RESIDUE at end of frame
m_len_o  out  LEN_W  bytes in frame, saturating
m_len_ovf_o  out  1  byte count saturated

Behaviour:
- Reset: state = IDLE, crc register = INIT, len = 0. s_ready_o = 1; m_valid_o = 0; m_crc_o = 0; m_ok_o = 0; m_len_o = 0; m_len_ovf_o = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: s_ready_o = 1. On an accepted byte: crc <= f(INIT, byte); len <= 1. Go to DONE if s_last_i, else to BUSY.
- BUSY: s_ready_o = 1. On an accepted byte: crc <= f(crc, byte); len increments. Go to DONE if s_last_i.
- A single-byte frame (s_last_i on the first byte) is legal and goes IDLE to DONE directly.
- No accepted byte: crc and len hold.
- Entering DONE: the result outputs are registered on the cycle the last byte is accepted. m_valid_o = 1 on the next cycle, giving latency 1 from the last-byte handshake.
- m_ok_o = (f(crc, last byte) == RESIDUE).
- DONE: s_ready_o = 0. Outputs stay stable while m_valid_o && !m_ready_i.
- Handshake on m_ready_i in DONE: m_valid_o falls next cycle, crc <= INIT, len <= 0, go to IDLE. One idle bubble per frame is allowed; sustained throughput is 1 byte/cycle within a frame.
- m_crc_o, m_ok_o, m_len_o and m_len_ovf_o hold their last values after the handshake. They are meaningful only while m_valid_o = 1.
- Length counter: counts accepted bytes and saturates at 2^LEN_W-1. m_len_ovf_o = 1 if any byte is accepted while the counter is already at max. The CRC is still computed over all bytes.
- abort_i in IDLE or BUSY: next state IDLE, crc <= INIT, len <= 0, no result produced. Abort has priority over a simultaneous byte handshake; that byte is consumed and discarded.
- abort_i in DONE: ignored; the result must still be handshaken.
- s_valid_i is sampled only when s_ready_o = 1. s_data_i and s_last_i are don't-care when s_valid_i = 0.
- Reset asserted mid-frame: immediately returns to the reset values above, with no result.
- The CRC function is the standard reflected byte update. f(0xFFFFFFFF, 0x00) followed by XOR_OUT gives 0xD202EF8D.

Test Plan:
- Single-cycle stream "123456789" (0x31..0x39), last on 0x39, m_ready_i = 1 -> one cycle later m_valid_o = 1, m_crc_o = 0xCBF43926, m_len_o = 9, m_ok_o = 0; next cycle back in IDLE.
- Single byte 0x00 with s_last_i -> m_crc_o = 0xD202EF8D, m_len_o = 1.
- "123456789" followed by FCS bytes 0x26, 0x39, 0xF4, 0xCB (last on 0xCB) -> m_ok_o = 1, m_crc_o = 0x2144DF1C, m_len_o = 13. Flip one data bit -> m_ok_o = 0.
- Result backpressure: m_ready_i low for 5 cycles after m_valid_o -> outputs stable and s_ready_o = 0 throughout. A second "123456789" frame sent immediately after the handshake -> again 0xCBF43926, showing the register was re-initialised.
- abort_i after byte 4 of a frame, then a clean "123456789" -> no result for the aborted frame; next result = 0xCBF43926. Also drive abort_i with s_last_i in the same cycle -> no result.
- Assert rst_ni low mid-frame and mid-DONE -> all outputs at reset values asynchronously. A following frame is correct. With LEN_W = 4, a 20-byte frame -> m_len_o = 15, m_len_ovf_o = 1, CRC matches the golden model.
